chess_clock_ctrl: RTL and testbench

Game controller for the two-player chess clock. It sits upstream of the two per-player clock stages and consumes their move-button clicks and zero flags. It drives each stage's restart, stop and win inputs, and the latched initial time. It owns whose clock runs, pause, flag-fall and the end-of-game result.

---
 rtl/chess_clock_pkg.sv | 16 +
 rtl/chess_clock_move_cnt.sv | 29 ++
 rtl/chess_clock_ctrl.sv | 102 ++++++++++
 tb/tb_chess_clock_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the chess clock game controller.
// The optional move counter is enabled by CHESS_CLOCK_MOVE_CNT_EN.
package chess_clock_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN_A   = 3'd1,
      RUN_B   = 3'd2,
      PAUSE_A = 3'd3,
      PAUSE_B = 3'd4,
      OVER    = 3'd5
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
endpackage

// File: rtl/chess_clock_move_cnt.sv
// Two-digit saturating BCD full-move counter with synchronous clear.
// Used only when CHESS_CLOCK_MOVE_CNT_EN is defined.
module chess_clock_move_cnt
   import chess_clock_pkg::*;
(
   input  logic       gclk,
   input  logic       grst_n,
   input  logic       clr,
   input  logic       inc,
   output bcd_t [1:0] cnt
);
   logic sat;
   assign sat = (cnt[1] == BCD_MAX) && (cnt[0] == BCD_MAX);

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && !sat) begin
         if (cnt[0] == BCD_MAX) begin
            cnt[0] <= '0;
            cnt[1] <= cnt[1] + 4'd1;
         end else begin
            cnt[0] <= cnt[0] + 4'd1;
         end
      end
   end
endmodule

// File: rtl/chess_clock_ctrl.sv
// Chess clock game controller: turn hand-off, pause, flag fall and result.
// Define CHESS_CLOCK_MOVE_CNT_EN to build the full-move counter on o_moves.
module chess_clock_ctrl
   import chess_clock_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_turn_a,
   input  logic       i_turn_b,
   input  logic       i_zero_a,
   input  logic       i_zero_b,
   input  logic       i_new,
   input  logic       i_pause,
   input  bcd_t [1:0] i_init,
   output bcd_t [1:0] o_init,
   output logic       o_restart,
   output logic       o_stop_a,
   output logic       o_stop_b,
   output logic       o_win_a,
   output logic       o_win_b,
   output logic [2:0] o_state,
   output bcd_t [1:0] o_moves
);
   state_t state, nxt;
   logic   nxt_win_a, nxt_win_b;

   always_comb begin
      nxt       = state;
      nxt_win_a = o_win_a;
      nxt_win_b = o_win_b;
      if (i_new) begin
         nxt       = IDLE;
         nxt_win_a = 1'b0;
         nxt_win_b = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_turn_a && !i_turn_b)      nxt = RUN_B;
               else if (i_turn_b && !i_turn_a) nxt = RUN_A;
            end
            // flag fall beats a same-cycle move click
            RUN_A: begin
               if (i_zero_a) begin
                  nxt       = OVER;
                  nxt_win_b = 1'b1;
               end else if (i_pause)  nxt = PAUSE_A;
               else if (i_turn_a)     nxt = RUN_B;
            end
            RUN_B: begin
               if (i_zero_b) begin
                  nxt       = OVER;
                  nxt_win_a = 1'b1;
               end else if (i_pause)  nxt = PAUSE_B;
               else if (i_turn_b)     nxt = RUN_A;
            end
            PAUSE_A: if (i_pause) nxt = RUN_A;
            PAUSE_B: if (i_pause) nxt = RUN_B;
            OVER:    nxt = OVER;
            default: nxt = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they change with it.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state     <= IDLE;
         o_restart <= 1'b1;
         o_stop_a  <= 1'b1;
         o_stop_b  <= 1'b1;
         o_win_a   <= 1'b0;
         o_win_b   <= 1'b0;
         o_init    <= '0;
      end else begin
         state     <= nxt;
         o_restart <= (nxt == IDLE);
         o_stop_a  <= (nxt != RUN_A);
         o_stop_b  <= (nxt != RUN_B);
         o_win_a   <= nxt_win_a;
         o_win_b   <= nxt_win_b;
         if (state == IDLE) o_init <= i_init;
      end
   end

   assign o_state = state;

`ifdef CHESS_CLOCK_MOVE_CNT_EN
   logic mv_inc, mv_clr;
   assign mv_inc = (state == RUN_B) && (nxt == RUN_A);
   assign mv_clr = (nxt == IDLE);

   chess_clock_move_cnt u_move_cnt (
      .gclk   (i_clk),
      .grst_n (i_rst),
      .clr    (mv_clr),
      .inc    (mv_inc),
      .cnt    (o_moves)
   );
`else
   assign o_moves = '0;
`endif
endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Self-checking bench for chess_clock_ctrl against a player-level game model.
// Expected o_moves depends on CHESS_CLOCK_MOVE_CNT_EN.
module tb_chess_clock_ctrl;
   logic            i_clk = 1'b0;
   logic            i_rst = 1'b0;
   logic            i_turn_a = 1'b0, i_turn_b = 1'b0;
   logic            i_zero_a = 1'b0, i_zero_b = 1'b0;
   logic            i_new = 1'b0, i_pause = 1'b0;
   logic [1:0][3:0] i_init = '0;
   logic [1:0][3:0] o_init, o_moves;
   logic            o_restart, o_stop_a, o_stop_b, o_win_a, o_win_b;
   logic [2:0]      o_state;

   chess_clock_ctrl dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_turn_a(i_turn_a), .i_turn_b(i_turn_b),
      .i_zero_a(i_zero_a), .i_zero_b(i_zero_b), .i_new(i_new), .i_pause(i_pause),
      .i_init(i_init), .o_init(o_init), .o_restart(o_restart), .o_stop_a(o_stop_a),
      .o_stop_b(o_stop_b), .o_win_a(o_win_a), .o_win_b(o_win_b), .o_state(o_state),
      .o_moves(o_moves)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0, passes = 0;

   // game model: who is on move (0 none, 1 A, 2 B), paused, game over, winner
   int   m_run = 0, m_win = 0, m_moves = 0;
   bit   m_paused = 0, m_over = 0;
   logic [7:0] m_preset = 8'h00;

   logic [20:0] act;
   assign act = {o_restart, o_stop_a, o_stop_b, o_win_a, o_win_b, o_init, o_moves};

   function automatic logic [20:0] exp_vec();
      logic idle, a_cnt, b_cnt;
      logic [7:0] mv;
      idle  = (m_run == 0) && !m_over;
      a_cnt = (m_run == 1) && !m_paused && !m_over;
      b_cnt = (m_run == 2) && !m_paused && !m_over;
`ifdef CHESS_CLOCK_MOVE_CNT_EN
      mv = {4'(m_moves / 10), 4'(m_moves % 10)};
`else
      mv = 8'h00;
`endif
      return {idle, !a_cnt, !b_cnt, m_over && m_win == 1, m_over && m_win == 2, m_preset, mv};
   endfunction

   task automatic model_reset();
      m_run = 0; m_win = 0; m_moves = 0; m_paused = 0; m_over = 0; m_preset = 8'h00;
   endtask

   task automatic model_edge(input logic ta, tb, za, zb, nw, ps, input logic [7:0] ini);
      bit zero, turn;
      if ((m_run == 0) && !m_over) m_preset = ini;
      if (nw) begin
         m_run = 0; m_paused = 0; m_over = 0; m_win = 0;
      end else if (m_over) begin
      end else if (m_run == 0) begin
         if (ta != tb) m_run = ta ? 2 : 1;
      end else if (m_paused) begin
         if (ps) m_paused = 0;
      end else begin
         zero = (m_run == 1) ? za : zb;
         turn = (m_run == 1) ? ta : tb;
         if (zero) begin
            m_over = 1; m_win = (m_run == 1) ? 2 : 1;
         end else if (ps) m_paused = 1;
         else if (turn) begin
            if (m_run == 2 && m_moves < 99) m_moves++;
            m_run = 3 - m_run;
         end
      end
      if ((m_run == 0) && !m_over) m_moves = 0;
   endtask

   task automatic step(input logic ta, tb, za, zb, nw, ps, input logic [7:0] ini);
      i_turn_a = ta; i_turn_b = tb; i_zero_a = za; i_zero_b = zb;
      i_new = nw; i_pause = ps; i_init = ini;
      @(posedge i_clk);
      model_edge(ta, tb, za, zb, nw, ps, ini);
      #1;
      i_turn_a = 0; i_turn_b = 0; i_zero_a = 0; i_zero_b = 0; i_new = 0; i_pause = 0;
   endtask

   task automatic test_reset();
      i_rst = 0; model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if (act !== exp_vec()) $display("FAIL reset act=%h exp=%h", act, exp_vec());
      else passes++;
      i_rst = 1;
   endtask

   task automatic test_preset();
      step(0,0,0,0,0,0,8'h30);
      checks++;
      if (act !== exp_vec()) $display("FAIL preset_30 act=%h exp=%h", act, exp_vec());
      else passes++;
      step(0,0,0,0,0,1,8'h45);
      checks++;
      if (act !== exp_vec()) $display("FAIL preset_45 act=%h exp=%h", act, exp_vec());
      else passes++;
   endtask

   task automatic test_start_handoff();
      step(0,1,0,0,0,0,8'h45);
      checks++;
      if (act !== exp_vec() || o_stop_a !== 1'b0) $display("FAIL start_a act=%h exp=%h", act, exp_vec());
      else passes++;
      step(0,0,0,0,0,0,8'h10);
      checks++;
      if (act !== exp_vec() || o_init !== 8'h45) $display("FAIL init_frozen act=%h exp=%h", act, exp_vec());
      else passes++;
      step(1,0,0,0,0,0,8'h10);
      checks++;
      if (act !== exp_vec() || o_stop_b !== 1'b0) $display("FAIL handoff act=%h exp=%h", act, exp_vec());
      else passes++;
      step(0,0,0,0,1,0,8'h45);
      step(1,1,0,0,0,0,8'h45);
      checks++;
      if (act !== exp_vec() || o_restart !== 1'b1) $display("FAIL both_turns act=%h exp=%h", act, exp_vec());
      else passes++;
   endtask

   task automatic test_flag_fall();
      step(0,1,0,0,0,0,8'h45);
      step(1,0,1,0,0,0,8'h45);
      checks++;
      if (act !== exp_vec() || o_win_b !== 1'b1) $display("FAIL flag_fall act=%h exp=%h", act, exp_vec());
      else passes++;
      step(1,0,0,0,0,0,8'h45);
      step(0,1,0,0,0,1,8'h45);
      checks++;
      if (act !== exp_vec()) $display("FAIL over_hold act=%h exp=%h", act, exp_vec());
      else passes++;
   endtask

   task automatic test_pause();
      step(0,0,0,0,1,0,8'h45);
      step(1,0,0,0,0,0,8'h45);
      step(0,0,0,0,0,1,8'h45);
      checks++;
      if (act !== exp_vec() || o_stop_b !== 1'b1) $display("FAIL pause act=%h exp=%h", act, exp_vec());
      else passes++;
      step(0,1,0,1,0,0,8'h45);
      checks++;
      if (act !== exp_vec()) $display("FAIL pause_ignore act=%h exp=%h", act, exp_vec());
      else passes++;
      step(0,0,0,0,0,1,8'h45);
      checks++;
      if (act !== exp_vec() || o_stop_b !== 1'b0) $display("FAIL resume act=%h exp=%h", act, exp_vec());
      else passes++;
   endtask

   task automatic test_new_async();
      step(0,0,0,1,0,0,8'h45);
      step(0,0,0,0,1,0,8'h45);
      checks++;
      if (act !== exp_vec() || o_win_a !== 1'b0) $display("FAIL new_game act=%h exp=%h", act, exp_vec());
      else passes++;
      step(0,1,0,0,0,0,8'h45);
      #2 i_rst = 0;
      model_reset();
      #1;
      checks++;
      if (act !== exp_vec()) $display("FAIL async_reset act=%h exp=%h", act, exp_vec());
      else passes++;
      @(negedge i_clk) i_rst = 1;
      @(posedge i_clk) #1;
   endtask

   task automatic test_preset_zero();
      step(0,0,0,0,1,0,8'h00);
      step(0,1,1,0,0,0,8'h00);
      checks++;
      if (act !== exp_vec()) $display("FAIL zero_start act=%h exp=%h", act, exp_vec());
      else passes++;
      step(0,0,1,0,0,0,8'h00);
      checks++;
      if (act !== exp_vec() || o_win_b !== 1'b1) $display("FAIL zero_over act=%h exp=%h", act, exp_vec());
      else passes++;
   endtask

   task automatic test_move_cnt();
      step(0,0,0,0,1,0,8'h59);
      step(1,0,0,0,0,0,8'h59);
      for (int i = 0; i < 100; i++) begin
         step(0,1,0,0,0,0,8'h59);
         step(1,0,0,0,0,0,8'h59);
         if (i == 4) begin
            checks++;
            if (act !== exp_vec()) $display("FAIL moves_5 act=%h exp=%h", act, exp_vec());
            else passes++;
         end
      end
      checks++;
      if (act !== exp_vec()) $display("FAIL moves_sat act=%h exp=%h", act, exp_vec());
      else passes++;
      step(0,0,0,0,1,0,8'h59);
      checks++;
      if (act !== exp_vec() || o_moves !== 8'h00) $display("FAIL moves_clr act=%h exp=%h", act, exp_vec());
      else passes++;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 2000; i++) begin
         step($urandom_range(2,0) == 0, $urandom_range(2,0) == 0,
              $urandom_range(19,0) == 0, $urandom_range(19,0) == 0,
              $urandom_range(59,0) == 0, $urandom_range(11,0) == 0,
              {4'($urandom_range(9,0)), 4'($urandom_range(9,0))});
         checks++;
         if (act !== exp_vec()) begin
            if (errs < 10) $display("FAIL random cyc=%0d act=%h exp=%h", i, act, exp_vec());
            errs++;
         end else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_preset();
      test_start_handoff();
      test_flag_fall();
      test_pause();
      test_new_async();
      test_preset_zero();
      test_move_cnt();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
